// File: rtl/sdram_line_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_line_fetch_if
//  Purpose  : Read-side bundle between the line fetcher and the SDRAM
//             controller read FIFO (address reload, pop, show-ahead data).
//  Revision : 1.0  initial release
// ============================================================================
interface sdram_line_fetch_if;
    logic        rd_load;   // reload read address, flush read FIFO
    logic [24:0] rd_addr;   // line start word address
    logic        rd_req;    // pop one word
    logic [15:0] rd_data;   // show-ahead FIFO head
    logic        rd_empty;  // FIFO empty flag

    // Fetcher side
    modport master (
        output rd_load,
        output rd_addr,
        output rd_req,
        input  rd_data,
        input  rd_empty
    );

    // Controller side
    modport slave (
        input  rd_load,
        input  rd_addr,
        input  rd_req,
        output rd_data,
        output rd_empty
    );
endinterface
`default_nettype wire

// File: rtl/sdram_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_line_fetch
//  Purpose  : Fetches one display line of 16-bit words from the SDRAM
//             controller read FIFO into a ping-pong line buffer; the VGA side
//             reads the other bank with one cycle of latency.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_line_fetch #(
    parameter int          LINE_WORDS = 320,
    parameter logic [24:0] BASE_ADDR  = 25'h0,
    parameter int          WDOG_MAX   = 1023
) (
    input  logic                pll_clk,
    input  logic                reset,
    input  logic                line_req,
    input  logic [9:0]          line_num,
    sdram_line_fetch_if.master  rd_bus,
    input  logic [8:0]          buf_addr,
    output logic [15:0]         buf_data,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic                timeout
);

    // Watchdog counts 0..WDOG_MAX-1; the abort happens on the empty cycle
    // that would make it reach WDOG_MAX.
    localparam int                    c_wdog_w     = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;
    localparam logic [c_wdog_w-1:0]   c_wdog_last  = c_wdog_w'(WDOG_MAX - 1);
    localparam logic [c_wdog_w-1:0]   c_wdog_one   = c_wdog_w'(1);
    localparam logic [8:0]            c_wcnt_last  = 9'(LINE_WORDS - 1);
    localparam logic [9:0]            c_line_words = 10'(LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_fill_bank;
    logic [8:0]            r_wcnt;
    logic [c_wdog_w-1:0]   r_wdog;
    logic [24:0]           r_rd_addr;
    logic                  r_overrun;
    logic                  r_timeout;
    logic [15:0]           r_buf_data;

    logic                  w_accept;     // line_req taken in IDLE
    logic                  w_pop;        // FETCH with data available
    logic                  w_wdog_exp;   // watchdog abort this cycle
    logic                  w_rd_req;
    logic                  w_rd_load;
    logic [24:0]           w_line_addr;

    // Two banks; the fill bank is written, the other one is displayed.
    logic [15:0]           r_bank0 [0:LINE_WORDS-1];
    logic [15:0]           r_bank1 [0:LINE_WORDS-1];

    // Line start address wraps modulo the 25-bit SDRAM word space.
    assign w_line_addr = 25'(BASE_ADDR + (25'(line_num) * 25'(LINE_WORDS)));

    // Next-state and control decode; strobes are forced low while reset is
    // high so an aborted fetch stops popping in the reset cycle itself.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        w_wdog_exp  = 1'b0;
        w_rd_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (line_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_rd_load   = 1'b1;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // FIFO flags right after a flush are not trusted.
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (!rd_bus.rd_empty) begin
                    w_pop = 1'b1;
                    if (r_wcnt == c_wcnt_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (r_wdog == c_wdog_last) begin
                    w_wdog_exp  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_rd_req  = w_pop & ~reset;
        w_rd_load = w_rd_load & ~reset;
    end

    assign rd_bus.rd_req  = w_rd_req;
    assign rd_bus.rd_load = w_rd_load;
    assign rd_bus.rd_addr = r_rd_addr;
    assign busy           = (r_state != ST_IDLE) & ~reset;
    assign done           = (r_state == ST_DONE) & ~reset;
    assign overrun        = r_overrun;
    assign timeout        = r_timeout;
    assign buf_data       = r_buf_data;

    // State register.
    always_ff @(posedge pll_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank select and line start address, captured when a request is taken.
    always_ff @(posedge pll_clk) begin
        if (reset) begin
            r_fill_bank <= 1'b0;
            r_rd_addr   <= 25'h0;
        end else if (w_accept) begin
            r_fill_bank <= ~r_fill_bank;
            r_rd_addr   <= w_line_addr;
        end
    end

    // Word counter and empty-stall watchdog for the fetch in progress.
    always_ff @(posedge pll_clk) begin
        if (reset) begin
            r_wcnt <= 9'd0;
            r_wdog <= '0;
        end else if (w_accept) begin
            r_wcnt <= 9'd0;
            r_wdog <= '0;
        end else if (r_state == ST_FETCH) begin
            if (w_pop) begin
                r_wcnt <= r_wcnt + 9'd1;
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + c_wdog_one;
            end
        end
    end

    // Sticky error flags; any non-IDLE state (DONE included) counts as busy.
    always_ff @(posedge pll_clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (line_req && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_wdog_exp) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Fill-side write into bank 0; RAM contents survive reset.
    always_ff @(posedge pll_clk) begin
        if (w_rd_req && !r_fill_bank) begin
            r_bank0[r_wcnt] <= rd_bus.rd_data;
        end
    end

    // Fill-side write into bank 1.
    always_ff @(posedge pll_clk) begin
        if (w_rd_req && r_fill_bank) begin
            r_bank1[r_wcnt] <= rd_bus.rd_data;
        end
    end

    // Display-side registered read; out-of-range addresses return zero.
    always_ff @(posedge pll_clk) begin
        if (reset) begin
            r_buf_data <= 16'h0000;
        end else if ({1'b0, buf_addr} >= c_line_words) begin
            r_buf_data <= 16'h0000;
        end else if (r_fill_bank) begin
            r_buf_data <= r_bank0[buf_addr];
        end else begin
            r_buf_data <= r_bank1[buf_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_line_fetch
//  Purpose  : Randomized self-checking bench for sdram_line_fetch with a
//             read-FIFO model and a line-buffer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_line_fetch;
    localparam int LW = 320;
    localparam int WD = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        line_req;
    logic [9:0]  line_num;
    logic [8:0]  buf_addr;
    logic [15:0] buf_data;
    logic        busy, done, overrun, timeout;

    logic        wrap_line_req;
    logic [8:0]  wrap_buf_addr;
    logic [15:0] wrap_buf_data;
    logic        wrap_busy, wrap_done, wrap_overrun, wrap_timeout;

    sdram_line_fetch_if rd_if ();
    sdram_line_fetch_if wrap_if ();

    sdram_line_fetch #(.LINE_WORDS(LW), .BASE_ADDR(25'h0), .WDOG_MAX(WD)) dut (
        .pll_clk (clk),       .reset   (reset),
        .line_req(line_req),  .line_num(line_num),
        .rd_bus  (rd_if.master),
        .buf_addr(buf_addr),  .buf_data(buf_data),
        .busy    (busy),      .done    (done),
        .overrun (overrun),   .timeout (timeout)
    );

    sdram_line_fetch #(.LINE_WORDS(LW), .BASE_ADDR(25'h1FFFF00), .WDOG_MAX(WD)) dut_wrap (
        .pll_clk (clk),           .reset   (reset),
        .line_req(wrap_line_req), .line_num(10'd1),
        .rd_bus  (wrap_if.master),
        .buf_addr(wrap_buf_addr), .buf_data(wrap_buf_data),
        .busy    (wrap_busy),     .done    (wrap_done),
        .overrun (wrap_overrun),  .timeout (wrap_timeout)
    );

    assign wrap_if.rd_data  = 16'h0000;
    assign wrap_if.rd_empty = 1'b1;

    // ---------------- read FIFO model ----------------
    // mode 0: never empty; mode 1: 3 cycles full / 3 cycles empty;
    // mode 2: supplies fifo_limit words then stays empty.
    int          pop_idx    = 0;
    int          stall_cnt  = 0;
    int          fifo_mode  = 0;
    int          fifo_limit = 0;
    logic [15:0] data_key   = 16'h0;

    always @(posedge clk) begin
        stall_cnt <= stall_cnt + 1;
        if (rd_if.rd_load)     pop_idx <= 0;
        else if (rd_if.rd_req) pop_idx <= pop_idx + 1;
    end

    always_comb begin
        rd_if.rd_data = 16'(pop_idx) ^ data_key;
        case (fifo_mode)
            0:       rd_if.rd_empty = 1'b0;
            1:       rd_if.rd_empty = (((stall_cnt / 3) % 2) == 1);
            default: rd_if.rd_empty = (pop_idx >= fifo_limit);
        endcase
    end

    // ---------------- reference model of the line buffer ----------------
    logic [15:0] mem [2][512];
    bit          vld [2][512];
    bit          fb       = 1'b0;   // bank currently being filled
    bit          exp_ovr  = 1'b0;
    bit          exp_to   = 1'b0;
    int          checks   = 0;
    int          errors   = 0;
    bit          rd_pend  = 1'b0;
    bit          rd_exp_vld = 1'b0;
    logic [15:0] rd_exp   = 16'h0;
    int          force_addr = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the previous display read, then launch a new one.
    task automatic step_buf(input bit allow_force);
        int a;
        int db;
        if (rd_pend && rd_exp_vld) check("buf_data", 32'(buf_data), 32'(rd_exp));
        if (allow_force && force_addr >= 0) begin
            a = force_addr;
            force_addr = -1;
        end else begin
            a = int'($urandom_range(0, 511));
        end
        buf_addr = 9'(a);
        db = fb ? 0 : 1;
        if (a >= LW) begin
            rd_exp     = 16'h0000;
            rd_exp_vld = 1'b1;
        end else begin
            rd_exp     = mem[db][a];
            rd_exp_vld = vld[db][a];
        end
        rd_pend = 1'b1;
    endtask

    task automatic run_line(input logic [9:0] ln, input int mode, input int limit,
                            input logic [15:0] key, input int extra_at, input int rst_at);
        int t, n, loads, bad_load, bad_win, bad_empty, dones, done_t, last_pop, exp_n;
        bit ended;
        logic [24:0] exp_addr;
        exp_addr = 25'(int'(ln) * LW);
        t = 0; n = 0; loads = 0; bad_load = 0; bad_win = 0; bad_empty = 0;
        dones = 0; done_t = -1; last_pop = -1; ended = 1'b0;
        @(negedge clk);
        step_buf(1'b0);
        fifo_mode  = mode;
        fifo_limit = limit;
        data_key   = key;
        line_num   = ln;
        line_req   = 1'b1;
        fb         = !fb;
        while (!ended && t < 4000) begin
            @(negedge clk);
            t++;
            line_req = 1'b0;
            if (rst_at > 0 && n == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_rd_req_now", 32'(rd_if.rd_req), 0);
                @(negedge clk);
                reset   = 1'b0;
                rd_pend = 1'b0;
                fb      = 1'b0;
                exp_ovr = 1'b0;
                exp_to  = 1'b0;
                check("rst_busy",     32'(busy), 0);
                check("rst_rd_req",   32'(rd_if.rd_req), 0);
                check("rst_rd_load",  32'(rd_if.rd_load), 0);
                check("rst_done",     32'(done), 0);
                check("rst_overrun",  32'(overrun), 0);
                check("rst_timeout",  32'(timeout), 0);
                check("rst_buf_data", 32'(buf_data), 0);
                check("rst_rd_addr",  32'(rd_if.rd_addr), 0);
                return;
            end
            step_buf(1'b1);
            if (t == 1) check("rd_addr", 32'(rd_if.rd_addr), 32'(exp_addr));
            if (rd_if.rd_load) begin
                loads++;
                if (t != 1) bad_load++;
            end
            if (rd_if.rd_req) begin
                if (t < 3 || n >= LW) bad_win++;
                if (rd_if.rd_empty) bad_empty++;
                if (n < 512) begin
                    mem[fb][n] = rd_if.rd_data;
                    vld[fb][n] = 1'b1;
                end
                n++;
                last_pop = t;
            end
            if (done) begin
                dones++;
                done_t = t;
            end
            if (t == extra_at) begin
                line_req = 1'b1;
                line_num = ~ln;
                exp_ovr  = 1'b1;
            end
            if (!busy) ended = 1'b1;
        end
        check("fetch_finished", 32'(ended), 1);
        exp_n = (mode == 2) ? limit : LW;
        check("pop_count", n, exp_n);
        check("rd_load_count", loads, 1);
        check("rd_load_window", bad_load, 0);
        check("rd_req_window", bad_win, 0);
        check("rd_req_when_empty", bad_empty, 0);
        if (mode == 2) begin
            exp_to = 1'b1;
            check("done_count", dones, 0);
            check("wdog_empty_run", t - last_pop - 1, WD);
        end else begin
            check("done_count", dones, 1);
            // Counting the line_req cycle as the first, done lands in cycle 324.
            if (mode == 0) check("done_cycle", done_t + 1, 324);
        end
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("timeout", 32'(timeout), 32'(exp_to));
        check("busy_idle", 32'(busy), 0);
        check("rd_addr_hold", 32'(rd_if.rd_addr), 32'(exp_addr));
    endtask

    function automatic logic [9:0] rnd_line();
        return 10'($urandom_range(0, 1023));
    endfunction

    initial begin
        #900000;
        $display("FAIL global_guard: observed no finish expected finish");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        reset         = 1'b1;
        line_req      = 1'b0;
        line_num      = 10'd0;
        buf_addr      = 9'd0;
        wrap_line_req = 1'b0;
        wrap_buf_addr = 9'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("init_busy",     32'(busy), 0);
        check("init_done",     32'(done), 0);
        check("init_overrun",  32'(overrun), 0);
        check("init_timeout",  32'(timeout), 0);
        check("init_rd_req",   32'(rd_if.rd_req), 0);
        check("init_rd_load",  32'(rd_if.rd_load), 0);
        check("init_buf_data", 32'(buf_data), 0);
        check("init_rd_addr",  32'(rd_if.rd_addr), 0);

        // Address wrap on the second instance.
        @(negedge clk);
        wrap_line_req = 1'b1;
        @(negedge clk);
        wrap_line_req = 1'b0;
        check("wrap_rd_load", 32'(wrap_if.rd_load), 1);
        check("wrap_rd_addr", 32'(wrap_if.rd_addr), 32'h0000040);

        // Plain fetch of line 2, data equals word index.
        run_line(10'd2, 0, 0, 16'h0000, -1, -1);
        // Next line reads back word 5 of line 2; extra request in the DONE cycle.
        force_addr = 5;
        run_line(rnd_line(), 0, 0, 16'($urandom), 323, -1);
        // Overrun 10 cycles into a fetch.
        run_line(rnd_line(), 0, 0, 16'($urandom), 10, -1);
        // Stalling FIFO.
        run_line(rnd_line(), 1, 0, 16'($urandom), -1, -1);
        // Watchdog: 100 words then permanently empty.
        run_line(rnd_line(), 2, 100, 16'($urandom), -1, -1);
        // Displays the partially refilled bank.
        run_line(rnd_line(), 0, 0, 16'($urandom), -1, -1);
        // Reset after 150 words.
        run_line(rnd_line(), 0, 0, 16'($urandom), -1, 150);
        // Fresh fetches after reset, then random mix.
        run_line(rnd_line(), 0, 0, 16'($urandom), -1, -1);
        run_line(rnd_line(), 1, 0, 16'($urandom), -1, -1);
        for (int i = 0; i < 3; i++) begin
            run_line(rnd_line(), int'($urandom_range(0, 1)), 0, 16'($urandom), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_line_fetch.md
SDRAM_LINE_FETCH -- requirements
Module: sdram_line_fetch

Interface
REQ-001 Parameter LINE_WORDS, default 320; 16-bit words fetched per display line.
REQ-002 Parameter BASE_ADDR, default 25'h0; SDRAM word address of line 0.
REQ-003 Parameter WDOG_MAX, default 1023; stall cycles allowed with FIFO empty before abort.
REQ-004 pll_clk  in  1  single clock; the SDRAM controller read-FIFO side clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 line_req  in  1  one-cycle pulse from VGA timing requesting the next line.
REQ-007 line_num  in  10  line index, sampled with line_req.
REQ-008 rd_load  out  1  to controller RD_LOAD; reloads read address and flushes read FIFO.
REQ-009 rd_addr  out  25  to controller RD_ADDR; line start address.
REQ-010 rd_req  out  1  to controller RD; pops one word from read FIFO.
REQ-011 rd_data  in  16  from controller RD_DATA; show-ahead, valid whenever rd_empty=0.
REQ-012 rd_empty  in  1  from controller RD_EMPTY.
REQ-013 buf_addr  in  9  VGA-side buffer read address (0..LINE_WORDS-1).
REQ-014 buf_data  out  16  VGA-side buffer read data, display bank.
REQ-015 busy  out  1  high while a fetch is in progress.
REQ-016 done  out  1  one-cycle pulse when a line is completely written.
REQ-017 overrun  out  1  sticky: line_req arrived while busy.
REQ-018 timeout  out  1  sticky: watchdog abort occurred.

Function
REQ-019 Buffer: two banks of LINE_WORDS x 16; fill_bank register selects write bank, display bank = ~fill_bank.
REQ-020 buf_data = display_bank[buf_addr], registered, latency 1 cycle; buf_addr >= LINE_WORDS returns 16'h0000.
REQ-021 FSM states IDLE, LOAD, SETTLE, FETCH, DONE.
REQ-022 IDLE: on line_req=1 -> fill_bank toggles, rd_addr <= BASE_ADDR + line_num*LINE_WORDS (mod 2^25), wcnt <= 0, wdog <= 0, go LOAD.
REQ-023 LOAD: rd_load=1 for exactly one cycle; go SETTLE.
REQ-024 SETTLE: one cycle, rd_req=0 (ignore stale FIFO flags after flush); go FETCH.
REQ-025 FETCH: rd_req = ~rd_empty (combinational); when rd_req=1, write rd_data to fill_bank[wcnt], wcnt++, wdog <= 0.
REQ-026 FETCH: when rd_req=1 and wcnt = LINE_WORDS-1 -> go DONE; no further rd_req issued.
REQ-027 FETCH: when rd_empty=1, wdog++; wdog = WDOG_MAX -> timeout <= 1, go IDLE; unwritten words keep prior contents.
REQ-028 DONE: done=1 one cycle; go IDLE.
REQ-029 busy=1 in LOAD, SETTLE, FETCH, DONE; busy=0 in IDLE.
REQ-030 line_req while busy: ignored (no bank swap, no restart), overrun <= 1.
REQ-031 line_req in the same cycle as DONE: counts as busy -> ignored, overrun set.
REQ-032 rd_req never asserted outside FETCH; rd_load never asserted outside LOAD.
REQ-033 Bank write and VGA read of different banks may occur the same cycle; no stall.
REQ-034 wcnt width 9 bits; LINE_WORDS must be <= 512.

Reset
REQ-035 reset=1 at rising edge: state IDLE, fill_bank=0, wcnt=0, wdog=0, rd_addr=0.
REQ-036 Outputs under reset: rd_load=0, rd_req=0, busy=0, done=0, overrun=0, timeout=0, buf_data=0.
REQ-037 Reset mid-FETCH aborts at once; rd_req drops the same cycle reset is sampled; buffer RAM contents not cleared.

Verification
REQ-038 Line fetch: line_req, line_num=2, FIFO model always non-empty with data=index -> rd_addr=25'd640, rd_load one cycle, exactly 320 rd_req pulses, done 324 cycles after line_req; next line_req, buf_addr=5 -> buf_data=5.
REQ-039 Stalling FIFO: rd_empty toggles every 3 cycles -> still exactly 320 pops, no write while rd_empty=1, done asserts, timeout=0.
REQ-040 Overrun: second line_req 10 cycles after first -> overrun=1, rd_addr unchanged, bank not swapped, first fetch completes normally.
REQ-041 Watchdog: FIFO supplies 100 words then stays empty -> timeout=1 after 1023 empty cycles, busy=0, no done pulse.
REQ-042 Reset mid-fetch at word 150 -> next cycle rd_req=0, busy=0, all flags 0; fresh line_req fetches 320 words correctly.
REQ-043 Address wrap: BASE_ADDR=25'h1FFFF00, line_num=1 -> rd_addr=25'h0000040.
